// File: rtl/systolic_pe_gen_if.sv
// Port bundle for one systolic PE: weight column chain, row data/psum path and status.
interface systolic_pe_gen_if #(
    parameter int unsigned TIME_STEPS   = 4,
    parameter int unsigned DATA_WIDTH   = 2,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned PSUM_WIDTH   = 20
);
    logic                                   weight_valid;
    logic signed [WEIGHT_WIDTH-1:0]         weights;
    logic                                   weight_swap;
    logic                                   weight_out_valid;
    logic signed [WEIGHT_WIDTH-1:0]         weight_out;
    logic                                   weight_swap_out;
    logic                                   in_data_valid;
    logic [TIME_STEPS*DATA_WIDTH-1:0]       in_raw_data;
    logic                                   out_data_valid;
    logic [TIME_STEPS*DATA_WIDTH-1:0]       out_raw_data;
    logic [TIME_STEPS*PSUM_WIDTH-1:0]       in_psum_data;
    logic                                   out_psum_valid;
    logic [TIME_STEPS*PSUM_WIDTH-1:0]       out_psum_data;
    logic                                   ovf_clr;
    logic                                   ovf_flag;
    logic                                   calc_ptr;

    modport master (
        output weight_valid, weights, weight_swap, in_data_valid, in_raw_data,
               in_psum_data, ovf_clr,
        input  weight_out_valid, weight_out, weight_swap_out, out_data_valid,
               out_raw_data, out_psum_valid, out_psum_data, ovf_flag, calc_ptr
    );

    modport slave (
        input  weight_valid, weights, weight_swap, in_data_valid, in_raw_data,
               in_psum_data, ovf_clr,
        output weight_out_valid, weight_out, weight_swap_out, out_data_valid,
               out_raw_data, out_psum_valid, out_psum_data, ovf_flag, calc_ptr
    );
endinterface

// File: rtl/systolic_pe_gen.sv
// Systolic PE: spike-count vector times a stationary ping-pong weight, added to the
// partial sums from above with optional saturation; two-cycle data-to-psum latency.
module systolic_pe_gen #(
    parameter int unsigned TIME_STEPS   = 4,
    parameter int unsigned DATA_WIDTH   = 2,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned PSUM_WIDTH   = 20,
    parameter int unsigned SATURATE     = 1
) (
    input logic               s_clk,
    input logic               s_rst_n,
    systolic_pe_gen_if.slave  bus
);
    localparam int unsigned PROD_WIDTH = WEIGHT_WIDTH + DATA_WIDTH + 1;
    localparam int unsigned SUM_WIDTH  = PSUM_WIDTH + 1;
    localparam int unsigned RAW_WIDTH  = TIME_STEPS * DATA_WIDTH;
    localparam int unsigned PSV_WIDTH  = TIME_STEPS * PSUM_WIDTH;
    localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

    if (PSUM_WIDTH < PROD_WIDTH) begin : g_bad_width
        $error("systolic_pe_gen: PSUM_WIDTH must be >= WEIGHT_WIDTH+DATA_WIDTH+1");
    end

    logic signed [WEIGHT_WIDTH-1:0] r_bank0;
    logic signed [WEIGHT_WIDTH-1:0] r_bank1;
    logic                           r_calc_ptr;
    logic                           r_weight_out_valid;
    logic signed [WEIGHT_WIDTH-1:0] r_weight_out;
    logic                           r_weight_swap_out;
    logic                           r_data_valid;
    logic [RAW_WIDTH-1:0]           r_raw_data;
    logic signed [PROD_WIDTH-1:0]   r_prod [TIME_STEPS];
    logic                           r_psum_valid;
    logic [PSV_WIDTH-1:0]           r_psum_data;
    logic                           r_ovf_flag;

    logic signed [WEIGHT_WIDTH-1:0] w_active_weight;
    logic signed [PROD_WIDTH-1:0]   w_weight_ext;
    logic signed [PROD_WIDTH-1:0]   w_prod [TIME_STEPS];
    logic signed [SUM_WIDTH-1:0]    w_sum [TIME_STEPS];
    logic [TIME_STEPS-1:0]          w_lane_ovf;
    logic [PSV_WIDTH-1:0]           w_psum_next;

    assign w_active_weight = r_calc_ptr ? r_bank1 : r_bank0;

    // Shadow write uses the pre-edge pointer, so a same-cycle swap activates the new weight.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_bank0    <= '0;
            r_bank1    <= '0;
            r_calc_ptr <= 1'b0;
        end else begin
            if (bus.weight_valid) begin
                if (r_calc_ptr) r_bank0 <= bus.weights;
                else            r_bank1 <= bus.weights;
            end
            if (bus.weight_swap) r_calc_ptr <= ~r_calc_ptr;
        end
    end

    // Column and row forwarding to the neighbouring PEs.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_weight_out_valid <= 1'b0;
            r_weight_out       <= '0;
            r_weight_swap_out  <= 1'b0;
            r_data_valid       <= 1'b0;
            r_raw_data         <= '0;
        end else begin
            r_weight_out_valid <= bus.weight_valid;
            r_weight_out       <= bus.weights;
            r_weight_swap_out  <= bus.weight_swap;
            r_data_valid       <= bus.in_data_valid;
            r_raw_data         <= bus.in_raw_data;
        end
    end

    // Shift-add multiply of each unsigned lane by the sign-extended active weight.
    always_comb begin
        w_weight_ext = PROD_WIDTH'(w_active_weight);
        for (int t = 0; t < int'(TIME_STEPS); t++) begin
            w_prod[t] = '0;
            for (int b = 0; b < int'(DATA_WIDTH); b++) begin
                if (bus.in_raw_data[t*int'(DATA_WIDTH) + b]) begin
                    w_prod[t] = w_prod[t] + (w_weight_ext <<< b);
                end
            end
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int t = 0; t < int'(TIME_STEPS); t++) r_prod[t] <= '0;
        end else if (bus.in_data_valid) begin
            for (int t = 0; t < int'(TIME_STEPS); t++) r_prod[t] <= w_prod[t];
        end
    end

    // One guard bit above PSUM_WIDTH; overflow when it disagrees with the lane sign bit.
    always_comb begin
        w_psum_next = '0;
        w_lane_ovf  = '0;
        for (int t = 0; t < int'(TIME_STEPS); t++) begin
            w_sum[t] = SUM_WIDTH'($signed(bus.in_psum_data[t*int'(PSUM_WIDTH) +: PSUM_WIDTH]))
                     + SUM_WIDTH'(r_prod[t]);
            w_lane_ovf[t] = w_sum[t][SUM_WIDTH-1] ^ w_sum[t][PSUM_WIDTH-1];
            if ((SATURATE != 0) && w_lane_ovf[t]) begin
                w_psum_next[t*int'(PSUM_WIDTH) +: PSUM_WIDTH] =
                    w_sum[t][SUM_WIDTH-1] ? PSUM_MIN : PSUM_MAX;
            end else begin
                w_psum_next[t*int'(PSUM_WIDTH) +: PSUM_WIDTH] = w_sum[t][PSUM_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_psum_valid <= 1'b0;
            r_psum_data  <= '0;
            r_ovf_flag   <= 1'b0;
        end else begin
            r_psum_valid <= r_data_valid;
            if (r_data_valid) r_psum_data <= w_psum_next;
            if (r_data_valid && (|w_lane_ovf)) r_ovf_flag <= 1'b1;
            else if (bus.ovf_clr)              r_ovf_flag <= 1'b0;
        end
    end

    assign bus.weight_out_valid = r_weight_out_valid;
    assign bus.weight_out       = r_weight_out;
    assign bus.weight_swap_out  = r_weight_swap_out;
    assign bus.out_data_valid   = r_data_valid;
    assign bus.out_raw_data     = r_raw_data;
    assign bus.out_psum_valid   = r_psum_valid;
    assign bus.out_psum_data    = r_psum_data;
    assign bus.ovf_flag         = r_ovf_flag;
    assign bus.calc_ptr         = r_calc_ptr;
endmodule
